alu_serial: RTL

Parametrised multi-cycle ALU for the DLX datapath, successor to the single-bit ALU slice. Processes a WIDTH-bit operation CHUNK bits per cycle, least-significant chunk first, and chains the carry across cycles in a register. Adds SLT/SLTU, overflow and zero flags, and an error flag. A valid/ready handshake on both sides lets the pipeline stall around it.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_chunk.sv | 34 +++
 rtl/alu_serial.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial DLX ALU: op codes, FSM states and
// the op-decode helpers used by both the top level and the chunk slice.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SLTU, OP_XOR, OP_SUB, OP_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One bit serves as both the initial carry-in and the B-invert select:
  // the subtract family computes a + ~b + 1, everything else a + b + 0.
  function automatic logic op_cin(input logic [3:0] op);
    case (op)
      OP_SUB, OP_SLT, OP_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit ALU slice; the carry chain spans only CHUNK bits.
// c_msb is the carry into the slice's top bit, used for overflow detection.
module alu_chunk
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [3:0]       op,
  input  logic             cin,
  output logic [CHUNK-1:0] y,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK-1:0] b_eff;
  logic [CHUNK:0]   sum;

  always_comb begin
    b_eff = op_cin(op) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    cout  = sum[CHUNK];
    // Carry into the top bit recovered from the top bit's own sum equation.
    c_msb = a[CHUNK-1] ^ b_eff[CHUNK-1] ^ sum[CHUNK-1];
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = sum[CHUNK-1:0];
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle ALU: WIDTH-bit operation processed CHUNK bits per cycle,
// LSB chunk first, with the carry chained through a register.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             err
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [3:0]       op_reg;
  logic [KW-1:0]    k;
  logic             carry_reg;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             err_q;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_y;
  logic             chunk_cout;
  logic             chunk_c_msb;

  logic [WIDTH-1:0] fin_sum;
  logic [WIDTH-1:0] fin_res;
  logic             fin_carry;
  logic             fin_ovf;
  logic             fin_zero;
  logic             ovf_raw;

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_chunk),
    .b     (b_chunk),
    .op    (op_reg),
    .cin   (carry_reg),
    .y     (chunk_y),
    .cout  (chunk_cout),
    .c_msb (chunk_c_msb)
  );

  // Fixups only matter on the last chunk, where chunk_* reflect the MSB slice.
  always_comb begin
    a_chunk   = a_reg[int'(k)*CHUNK +: CHUNK];
    b_chunk   = b_reg[int'(k)*CHUNK +: CHUNK];
    fin_sum   = res_reg;
    fin_sum[int'(k)*CHUNK +: CHUNK] = chunk_y;
    ovf_raw   = chunk_c_msb ^ chunk_cout;
    fin_res   = fin_sum;
    fin_carry = 1'b0;
    fin_ovf   = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        fin_carry = chunk_cout;
        fin_ovf   = ovf_raw;
      end
      OP_SLT: begin
        fin_res    = '0;
        fin_res[0] = fin_sum[WIDTH-1] ^ ovf_raw;
        fin_carry  = chunk_cout;
      end
      OP_SLTU: begin
        fin_res    = '0;
        fin_res[0] = ~chunk_cout;
        fin_carry  = chunk_cout;
      end
      default: ;
    endcase
    if (!is_legal_op(op_reg)) begin
      fin_res   = '0;
      fin_carry = 1'b0;
      fin_ovf   = 1'b0;
    end
    fin_zero = (fin_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      k         <= '0;
      carry_reg <= 1'b0;
      res_reg   <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            k         <= '0;
            carry_reg <= op_cin(op);
            res_reg   <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            err_q     <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            k       <= '0;
            res_reg <= '0;
            state   <= IDLE;
          end else if (k == K_LAST) begin
            res_reg   <= fin_res;
            carry_reg <= chunk_cout;
            carry_q   <= fin_carry;
            ovf_q     <= fin_ovf;
            zero_q    <= fin_zero;
            err_q     <= !is_legal_op(op_reg);
            k         <= '0;
            state     <= DONE;
          end else begin
            res_reg[int'(k)*CHUNK +: CHUNK] <= chunk_y;
            carry_reg <= chunk_cout;
            k         <= k + KW'(1);
          end
        end
        DONE: begin
          // Abort discards the result; a normal handoff leaves it in place.
          if (abort) begin
            res_reg <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_reg;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
